// File: rtl/seg_display_driver_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Hex patterns are active-high {g,f,e,d,c,b,a}; polarity is applied by the driver.
package seg_display_driver_pkg;

  localparam int NUM_SEG_DIGITS = 3;

  localparam logic [7:0] SEG_OFF_ACTIVE_LOW  = 8'hFF;
  localparam logic [7:0] SEG_OFF_ACTIVE_HIGH = 8'h00;
  localparam logic [NUM_SEG_DIGITS-1:0] SEG_EN_OFF_ACTIVE_LOW  = '1;
  localparam logic [NUM_SEG_DIGITS-1:0] SEG_EN_OFF_ACTIVE_HIGH = '0;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Counter width able to hold 0 .. max_cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Status-word input and segment/anode output bundle of the display driver.
// master = status logic / pin side, slave = the driver itself.
interface seg_display_driver_if;
  import seg_display_driver_pkg::*;

  logic [4*NUM_SEG_DIGITS-1:0] digits_in;
  logic [NUM_SEG_DIGITS-1:0]   dp_in;
  logic                        enable;
  logic [7:0]                  seg_out;
  logic [NUM_SEG_DIGITS-1:0]   seg_en;
  logic                        scan_done;

  modport master (
    output digits_in, dp_in, enable,
    input  seg_out, seg_en, scan_done
  );

  modport slave (
    input  digits_in, dp_in, enable,
    output seg_out, seg_en, scan_done
  );
endinterface

// File: rtl/seg_display_driver_hex_to_seg.sv
// Combinational hex nibble to active-high a..g segment decoder.
// Polarity-neutral so it can be reused by other display logic.
module hex_to_seg
  import seg_display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX_0;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_HEX_0;
    endcase
  end

endmodule

// File: rtl/seg_display_driver.sv
// Multiplexed 3-digit 7-segment scanner: blank gap, then one digit driven, per digit.
// Input is snapshotted once per scan; all outputs are registered from next-state values.
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  seg_display_driver_if.slave bus
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW         = cnt_width(MAX_CYCLES);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(NUM_SEG_DIGITS - 1);

  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? SEG_OFF_ACTIVE_LOW : SEG_OFF_ACTIVE_HIGH;
  localparam logic [NUM_SEG_DIGITS-1:0] EN_OFF =
      ACTIVE_LOW ? SEG_EN_OFF_ACTIVE_LOW : SEG_EN_OFF_ACTIVE_HIGH;

  scan_state_t                 state_reg, state_next;
  logic [1:0]                  idx_reg, idx_next;
  logic [CW-1:0]               count_reg, count_next;
  logic [4*NUM_SEG_DIGITS-1:0] digits_snap_reg, digits_snap_next;
  logic [NUM_SEG_DIGITS-1:0]   dp_snap_reg, dp_snap_next;
  logic [7:0]                  seg_out_reg, seg_out_next;
  logic [NUM_SEG_DIGITS-1:0]   seg_en_reg, seg_en_next;
  logic                        scan_done_reg, scan_done_next;

  logic                        snap_load;
  logic [6:0]                  digit_seg [NUM_SEG_DIGITS];
  logic [7:0]                  active_seg;
  logic [NUM_SEG_DIGITS-1:0]   active_en;

  // Snapshot is taken at the start of every scan so a scan is always self-consistent.
  assign snap_load = bus.enable && (state_reg == ST_BLANK) && (idx_reg == 2'd0) && (count_reg == '0);

  always_comb begin
    digits_snap_next = digits_snap_reg;
    dp_snap_next     = dp_snap_reg;
    if (snap_load) begin
      digits_snap_next = bus.digits_in;
      dp_snap_next     = bus.dp_in;
    end
  end

  // Decode from the next snapshot so a one-cycle blank gap still shows fresh data.
  generate
    for (genvar gi = 0; gi < NUM_SEG_DIGITS; gi++) begin : g_decode
      hex_to_seg u_hex_to_seg (
        .nibble (digits_snap_next[4*gi +: 4]),
        .seg    (digit_seg[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    count_next     = count_reg;
    scan_done_next = 1'b0;
    seg_out_next   = SEG_OFF;
    seg_en_next    = EN_OFF;
    active_seg     = 8'h00;
    active_en      = '0;

    if (!bus.enable) begin
      state_next = ST_BLANK;
      idx_next   = 2'd0;
      count_next = '0;
    end else begin
      case (state_reg)
        ST_BLANK: begin
          if (count_reg == BLANK_LAST) begin
            state_next = ST_DRIVE;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (count_reg == DIGIT_LAST) begin
            state_next = ST_BLANK;
            count_next = '0;
            if (idx_reg == IDX_LAST) begin
              idx_next       = 2'd0;
              scan_done_next = 1'b1;
            end else begin
              idx_next = idx_reg + 2'd1;
            end
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        default: begin
          state_next = ST_BLANK;
          idx_next   = 2'd0;
          count_next = '0;
        end
      endcase
    end

    if (state_next == ST_DRIVE) begin
      active_seg   = {dp_snap_next[idx_next], digit_seg[idx_next]};
      active_en    = NUM_SEG_DIGITS'(1) << idx_next;
      seg_out_next = ACTIVE_LOW ? ~active_seg : active_seg;
      seg_en_next  = ACTIVE_LOW ? ~active_en : active_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_BLANK;
      idx_reg         <= 2'd0;
      count_reg       <= '0;
      digits_snap_reg <= '0;
      dp_snap_reg     <= '0;
      seg_out_reg     <= SEG_OFF;
      seg_en_reg      <= EN_OFF;
      scan_done_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      count_reg       <= count_next;
      digits_snap_reg <= digits_snap_next;
      dp_snap_reg     <= dp_snap_next;
      seg_out_reg     <= seg_out_next;
      seg_en_reg      <= seg_en_next;
      scan_done_reg   <= scan_done_next;
    end
  end

  assign bus.seg_out   = seg_out_reg;
  assign bus.seg_en    = seg_en_reg;
  assign bus.scan_done = scan_done_reg;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with BLANK_CYCLES=2, DIGIT_CYCLES=4.
// An active-low and an active-high instance run side by side.
module tb_seg_display_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  seg_display_driver_if bus_al ();
  seg_display_driver_if bus_ah ();

  seg_display_driver #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_al)
  );

  seg_display_driver #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ah)
  );

  // Active-high a..g patterns for 0..F.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One scan of 18 edges: k=1 blank, 2..5 digit0, 6..7 blank, 8..11 digit1,
  // 12..13 blank, 14..17 digit2, 18 blank with scan_done.
  task automatic scan(input string name, input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input int stop_k, input bit chk_pol,
                      input bit chg, input logic [11:0] chg_digits);
    logic [7:0] exp_seg;
    logic [2:0] exp_en;
    logic [7:0] exp_pol_seg;
    for (int k = 1; k <= stop_k; k++) begin
      step();
      exp_seg     = 8'hFF;
      exp_en      = 3'b111;
      exp_pol_seg = 8'h00;
      if (k >= 2 && k <= 5) begin
        exp_en = 3'b110; exp_seg = s0; exp_pol_seg = 8'h7F;
      end else if (k >= 8 && k <= 11) begin
        exp_en = 3'b101; exp_seg = s1; exp_pol_seg = 8'h3F;
      end else if (k >= 14 && k <= 17) begin
        exp_en = 3'b011; exp_seg = s2; exp_pol_seg = 8'h3F;
      end
      check8($sformatf("%s k%0d seg_en", name, k), {5'b0, bus_al.seg_en}, {5'b0, exp_en});
      check8($sformatf("%s k%0d seg_out", name, k), bus_al.seg_out, exp_seg);
      check8($sformatf("%s k%0d scan_done", name, k), {7'b0, bus_al.scan_done},
             (k == 18) ? 8'd1 : 8'd0);
      if (chk_pol) begin
        check8($sformatf("%s k%0d pol seg_en", name, k), {5'b0, bus_ah.seg_en}, {5'b0, ~exp_en});
        check8($sformatf("%s k%0d pol seg_out", name, k), bus_ah.seg_out, exp_pol_seg);
      end
      if (chg && k == 9) bus_al.digits_in = chg_digits;
    end
    $display("scan %s: %0d edges, checks so far %0d", name, stop_k, n_checks);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_al.digits_in = 12'h3A7;
    bus_al.dp_in     = 3'b000;
    bus_al.enable    = 1'b1;
    bus_ah.digits_in = 12'h008;
    bus_ah.dp_in     = 3'b000;
    bus_ah.enable    = 1'b1;

    repeat (3) step();
    check8("reset seg_en", {5'b0, bus_al.seg_en}, 8'h07);
    check8("reset seg_out", bus_al.seg_out, 8'hFF);
    check8("reset scan_done", {7'b0, bus_al.scan_done}, 8'h00);
    check8("reset pol seg_en", {5'b0, bus_ah.seg_en}, 8'h00);
    check8("reset pol seg_out", bus_ah.seg_out, 8'h00);
    $display("reset: outputs checked while rst_n low");
    rst_n = 1'b1;

    // Basic scan of 3A7; input switches to FFF during digit 1.
    scan("basic", 8'hF8, 8'h88, 8'hB0, 18, 1'b1, 1'b1, 12'hFFF);
    scan("snapshot", 8'h8E, 8'h8E, 8'h8E, 18, 1'b0, 1'b0, 12'h000);

    // Full decode on digit 0 with its decimal point lit.
    for (int v = 0; v < 16; v++) begin
      bus_al.digits_in = 12'(v);
      bus_al.dp_in     = 3'b001;
      scan($sformatf("decode_%0h", v), ~{1'b1, hex_tab[v]}, 8'hC0, 8'hC0, 18,
           1'b0, 1'b0, 12'h000);
    end

    // Enable dropped mid digit-1 DRIVE.
    bus_al.digits_in = 12'h3A7;
    bus_al.dp_in     = 3'b000;
    scan("en_run", 8'hF8, 8'h88, 8'hB0, 9, 1'b0, 1'b0, 12'h000);
    bus_al.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check8($sformatf("en_off %0d seg_en", i), {5'b0, bus_al.seg_en}, 8'h07);
      check8($sformatf("en_off %0d seg_out", i), bus_al.seg_out, 8'hFF);
      check8($sformatf("en_off %0d scan_done", i), {7'b0, bus_al.scan_done}, 8'h00);
    end
    $display("enable low: 3 edges blank");
    bus_al.digits_in = 12'h5C1;
    bus_al.enable    = 1'b1;
    scan("en_restore", 8'hF9, 8'hC6, 8'h92, 18, 1'b0, 1'b0, 12'h000);

    // Asynchronous reset between edges during digit-2 DRIVE.
    scan("pre_reset", 8'hF9, 8'hC6, 8'h92, 15, 1'b0, 1'b0, 12'h000);
    bus_al.digits_in = 12'h2E4;
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_rst seg_en", {5'b0, bus_al.seg_en}, 8'h07);
    check8("async_rst seg_out", bus_al.seg_out, 8'hFF);
    check8("async_rst scan_done", {7'b0, bus_al.scan_done}, 8'h00);
    check8("async_rst pol seg_en", {5'b0, bus_ah.seg_en}, 8'h00);
    $display("async reset: outputs checked with no clock edge");
    #1;
    rst_n = 1'b1;
    scan("post_reset", 8'h99, 8'h86, 8'hA4, 18, 1'b0, 1'b0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
